dtack_generator: RTL and testbench
==================================

# dtack_generator

Generates the 68000 data-transfer acknowledge (DTACK_L) and bus-error (BERR_L) for every CPU bus cycle, downstream of the address decoder. It consumes the decoder's region selects and the CPU address strobe, and inserts a per-region number of wait states before acknowledging. DRAM cycles take their acknowledge from the DRAM controller. Cycles that are never acknowledged end in a bus error after a timeout.

## Interface
- ROM_WAIT, default 0: wait states for on-chip ROM (0–15).
- RAM_WAIT, default 0: wait states for on-chip RAM (0–15).
- IO_WAIT, default 2: wait states for the IO region (0–15).
- CAN_WAIT, default 4: wait states for the CAN bus region (0–15).
- TIMEOUT_CYCLES, default 256: clocks from cycle start to BERR_L (16–65535).

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset_H  in  1  asynchronous, active-high reset.
- AS_L  in  1  CPU address strobe, synchronous to Clock.
- OnChipRomSelect_H, OnChipRamSelect_H, DramSelect_H, IOSelect_H, CanBusSelect_H  in  1 each  decoder region selects.
- DramDtack_L  in  1  acknowledge from the DRAM controller.
- DTACK_L  out  1  acknowledge to the CPU, registered.
- BERR_L  out  1  bus error to the CPU, registered.
- Busy_H  out  1  high while a bus cycle is being tracked.

## Operation
- States are IDLE, WAIT, ACK, BERR and HOLD.
- **IDLE**
  - AS_L sampled low latches the region with fixed priority ROM > RAM > IO > CAN > DRAM > NONE.
  - Priority is mandatory: the on-chip RAM and DRAM decodes overlap at 0800_0000–0803_FFFF, and on-chip RAM wins there.
  - ROM, RAM, IO and CAN regions load a 4-bit wait counter with their parameter and go to WAIT.
  - DRAM and NONE regions go to WAIT with the counter unused.
- **WAIT**
  - Counter regions: when the counter is 0, go to ACK; otherwise decrement.
  - DRAM region: go to ACK on the first edge DramDtack_L is sampled low.
  - NONE region: stay in WAIT until the timeout.
- **ACK**: DTACK_L is low. Go to HOLD.
- **HOLD**: DTACK_L stays low until AS_L is sampled high, then go to IDLE with DTACK_L high.
- **BERR** (timeout feature only): BERR_L is low until AS_L is sampled high, then go to IDLE.
- **Abort**: AS_L sampled high while in WAIT returns to IDLE without asserting DTACK_L or BERR_L.
- DTACK_L and BERR_L are never low together.
- Busy_H is high in every state except IDLE.

## Timing
- Reset values: DTACK_L=1, BERR_L=1, Busy_H=0, state IDLE, both counters 0.
- Reset takes effect immediately, including mid-cycle.
- Latency, counting edge E as the first edge that samples AS_L low:
  - Counter regions: DTACK_L goes low after edge E+WAIT+2. With WAIT=0 that is 2 clocks.
  - DRAM: DTACK_L goes low after edge D+1, where D is the edge that samples DramDtack_L low.
- DTACK_L goes high after the edge following the edge that samples AS_L high. Back-to-back cycles therefore need AS_L high for at least one edge.
- Timeout counter:
  - 16 bits, cleared at edge E, incremented in WAIT.
  - When it reaches TIMEOUT_CYCLES-1, the state goes to BERR in place of continuing to wait.
  - If acknowledge and timeout occur on the same edge, acknowledge wins.
- Selects are sampled only at edge E. Changes to them during the cycle are ignored.

## Configuration
- DTACK_BUS_TIMEOUT_EN defined:
  - The watchdog is present, and unacknowledged cycles end in BERR.
- DTACK_BUS_TIMEOUT_EN undefined:
  - There is no watchdog and no BERR state, and BERR_L is tied high.
  - Unacknowledged cycles (NONE region, or a DRAM controller that never acknowledges) stay in WAIT until AS_L rises.

## Structure
- Package dtack_pkg holds:
  - the state enum (IDLE, WAIT, ACK, BERR, HOLD);
  - the region enum (ROM, RAM, IO, CAN, DRAM, NONE);
  - the wait-counter width constant (4).
- Sub-module bus_timeout_watchdog: the 16-bit timeout counter, with clear and enable inputs and an expired output. It is instantiated only under DTACK_BUS_TIMEOUT_EN.

## Test plan
- After reset: DTACK_L=1, BERR_L=1, Busy_H=0. AS_L low with ROM select and ROM_WAIT=0 → DTACK_L low 2 clocks after edge E, and high one clock after AS_L rises.
- IO select with IO_WAIT=2 → DTACK_L low exactly 4 clocks after edge E. Busy_H is high from edge E until the clock after AS_L rises.
- RAM and DRAM selects both high → RAM timing; DramDtack_L is ignored. DRAM select alone, with DramDtack_L low 5 clocks after E → DTACK_L low one clock later.
- No select, TIMEOUT_CYCLES=16, macro defined → BERR_L low after 16 WAIT clocks and DTACK_L never asserted. With the macro undefined → no BERR_L, and AS_L high returns to IDLE.
- AS_L rises mid-WAIT in a CAN cycle → no DTACK_L, and the next cycle starts normally.
- Reset_H pulsed asynchronously during HOLD → DTACK_L high immediately and the state is IDLE.

Source files
------------

// File: rtl/dtack_pkg.sv
// Shared types and helpers for the 68000 DTACK/BERR generator.
package dtack_pkg;

   // Width of the per-region wait-state counter
   localparam int WAIT_W = 4;

   // Width of the bus-timeout counter
   localparam int TMO_W  = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ACK,
      S_BERR,
      S_HOLD
   } state_t;

   typedef enum logic [2:0] {
      R_ROM,
      R_RAM,
      R_IO,
      R_CAN,
      R_DRAM,
      R_NONE
   } region_t;

   // Fixed-priority region pick. On-chip RAM must beat DRAM because their
   // decodes overlap at 0800_0000-0803_FFFF.
   function automatic region_t decode_region(
      input logic rom,
      input logic ram,
      input logic io,
      input logic can,
      input logic dram
   );
      if (rom)       return R_ROM;
      else if (ram)  return R_RAM;
      else if (io)   return R_IO;
      else if (can)  return R_CAN;
      else if (dram) return R_DRAM;
      else           return R_NONE;
   endfunction

endpackage

// File: rtl/bus_timeout_watchdog.sv
// 16-bit bus-cycle watchdog: cleared at cycle start, counts while the
// cycle waits, flags expiry at TIMEOUT_CYCLES-1.
module bus_timeout_watchdog
   import dtack_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [TMO_W-1:0] count_reg;

   // Cycle counter: clear has priority over counting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (enable) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign expired = (count_reg == TMO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/dtack_generator.sv
// 68000 DTACK_L / BERR_L generator with per-region wait states.
// Optional bus-error watchdog enabled by defining DTACK_BUS_TIMEOUT_EN;
// without it BERR_L is tied high and unacknowledged cycles wait for AS_L.
module dtack_generator
   import dtack_pkg::*;
#(
   parameter int ROM_WAIT       = 0,
   parameter int RAM_WAIT       = 0,
   parameter int IO_WAIT        = 2,
   parameter int CAN_WAIT       = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic Clock,
   input  logic Reset_H,
   input  logic AS_L,
   input  logic OnChipRomSelect_H,
   input  logic OnChipRamSelect_H,
   input  logic DramSelect_H,
   input  logic IOSelect_H,
   input  logic CanBusSelect_H,
   input  logic DramDtack_L,
   output logic DTACK_L,
   output logic BERR_L,
   output logic Busy_H
);

   state_t              state_reg, state_next;
   region_t             region_reg, region_next;
   logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
   logic                dtack_l_reg;
   logic                ack_now;
   logic                wd_clear;
   logic                wd_enable;
   logic                timeout_hit;

   // Wait-state preload for a freshly latched region
   function automatic logic [WAIT_W-1:0] wait_load(input region_t r);
      case (r)
         R_ROM:   return WAIT_W'(ROM_WAIT);
         R_RAM:   return WAIT_W'(RAM_WAIT);
         R_IO:    return WAIT_W'(IO_WAIT);
         R_CAN:   return WAIT_W'(CAN_WAIT);
         default: return '0;
      endcase
   endfunction

   // State, region and wait-counter registers
   always_ff @(posedge Clock or posedge Reset_H) begin
      if (Reset_H) begin
         state_reg    <= S_IDLE;
         region_reg   <= R_NONE;
         wait_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         region_reg   <= region_next;
         wait_cnt_reg <= wait_cnt_next;
      end
   end

   // Next-state logic; abort beats acknowledge, acknowledge beats timeout
   always_comb begin
      state_next    = state_reg;
      region_next   = region_reg;
      wait_cnt_next = wait_cnt_reg;
      ack_now       = 1'b0;
      wd_clear      = 1'b0;
      wd_enable     = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (!AS_L) begin
               region_next   = decode_region(OnChipRomSelect_H, OnChipRamSelect_H,
                                             IOSelect_H, CanBusSelect_H, DramSelect_H);
               wait_cnt_next = wait_load(region_next);
               wd_clear      = 1'b1;
               state_next    = S_WAIT;
            end
         end
         S_WAIT: begin
            wd_enable = 1'b1;
            if (AS_L) begin
               state_next = S_IDLE;
            end else begin
               case (region_reg)
                  R_DRAM:  ack_now = !DramDtack_L;
                  R_NONE:  ack_now = 1'b0;
                  default: begin
                     if (wait_cnt_reg == '0) begin
                        ack_now = 1'b1;
                     end else begin
                        wait_cnt_next = wait_cnt_reg - 1'b1;
                     end
                  end
               endcase
               if (ack_now) begin
                  state_next = S_ACK;
               end else if (timeout_hit) begin
                  state_next = S_BERR;
               end
            end
         end
         S_ACK: begin
            state_next = S_HOLD;
         end
         S_HOLD, S_BERR: begin
            if (AS_L) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // DTACK_L follows the current state one edge later, so it stays low
   // for the edge after AS_L is seen high
   always_ff @(posedge Clock or posedge Reset_H) begin
      if (Reset_H) begin
         dtack_l_reg <= 1'b1;
      end else begin
         dtack_l_reg <= !((state_reg == S_ACK) || (state_reg == S_HOLD));
      end
   end

   assign DTACK_L = dtack_l_reg;
   assign Busy_H  = (state_reg != S_IDLE);

`ifdef DTACK_BUS_TIMEOUT_EN
   logic berr_l_reg;

   bus_timeout_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (Clock),
      .rst     (Reset_H),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (timeout_hit)
   );

   // BERR_L is low exactly while the machine sits in BERR
   always_ff @(posedge Clock or posedge Reset_H) begin
      if (Reset_H) begin
         berr_l_reg <= 1'b1;
      end else begin
         berr_l_reg <= (state_next != S_BERR);
      end
   end

   assign BERR_L = berr_l_reg;
`else
   logic unused_wd;

   assign timeout_hit = 1'b0;
   assign unused_wd   = wd_clear ^ wd_enable;
   assign BERR_L      = 1'b1;
`endif

endmodule

// File: tb/tb_dtack_generator.sv
// Scoreboard bench for dtack_generator: each bus cycle pushes its expected
// outcome, a monitor measures the actual outcome and compares on AS_L rise.
module tb_dtack_generator;

   localparam int ROM_W = 0;
   localparam int RAM_W = 1;
   localparam int IO_W  = 2;
   localparam int CAN_W = 4;
   localparam int TMO   = 16;

   localparam int K_NONE = 0;
   localparam int K_ACK  = 1;
   localparam int K_BERR = 2;

   // select bit order: [0] rom [1] ram [2] dram [3] io [4] can
   localparam logic [4:0] SEL_ROM  = 5'b00001;
   localparam logic [4:0] SEL_RAM  = 5'b00010;
   localparam logic [4:0] SEL_DRAM = 5'b00100;
   localparam logic [4:0] SEL_IO   = 5'b01000;
   localparam logic [4:0] SEL_CAN  = 5'b10000;

   typedef struct {
      string tag;
      int    kind;
      int    lat;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       as_l = 1'b1;
   logic [4:0] sel = '0;
   logic       dram_dtack_l = 1'b1;
   logic       dtack_l, berr_l, busy;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   overlap_err = 0;
   bit   drop_cycle = 0;

   always #5 clk = ~clk;

   dtack_generator #(
      .ROM_WAIT       (ROM_W),
      .RAM_WAIT       (RAM_W),
      .IO_WAIT        (IO_W),
      .CAN_WAIT       (CAN_W),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .Clock             (clk),
      .Reset_H           (rst),
      .AS_L              (as_l),
      .OnChipRomSelect_H (sel[0]),
      .OnChipRamSelect_H (sel[1]),
      .DramSelect_H      (sel[2]),
      .IOSelect_H        (sel[3]),
      .CanBusSelect_H    (sel[4]),
      .DramDtack_L       (dram_dtack_l),
      .DTACK_L           (dtack_l),
      .BERR_L            (berr_l),
      .Busy_H            (busy)
   );

   task automatic check_eq(input string tag, input int actual, input int expected);
      n_checks++;
      if (actual == expected) begin
         n_pass++;
      end else begin
         $display("FAIL %s actual=%0d expected=%0d", tag, actual, expected);
      end
   endtask

   // Monitor: AS_L sampled at each rising edge, outputs 1 time unit later
   initial begin
      bit   in_cycle = 0;
      bit   post_check = 0;
      bit   as_s;
      int   edge_cnt = 0;
      int   e_edge = 0;
      int   got = K_NONE;
      int   lat = 0;
      exp_t ex;
      forever begin
         @(posedge clk);
         as_s = as_l;
         edge_cnt++;
         #1;
         if (!dtack_l && !berr_l) overlap_err++;
         if (drop_cycle) begin
            in_cycle   = 0;
            drop_cycle = 0;
         end
         if (post_check) begin
            check_eq("idle_dtack", dtack_l, 1);
            check_eq("idle_berr", berr_l, 1);
            post_check = 0;
         end
         if (!in_cycle) begin
            if (!as_s) begin
               in_cycle = 1;
               e_edge   = edge_cnt;
               got      = K_NONE;
               lat      = 0;
               check_eq("busy_start", busy, 1);
            end
         end else if (as_s) begin
            in_cycle = 0;
            if (sb.size() == 0) begin
               check_eq("sb_underflow", 0, 1);
            end else begin
               ex = sb.pop_front();
               $display("txn %s kind=%0d lat=%0d (want kind=%0d lat=%0d)",
                        ex.tag, got, lat, ex.kind, ex.lat);
               check_eq({ex.tag, "_kind"}, got, ex.kind);
               check_eq({ex.tag, "_lat"}, lat, ex.lat);
               check_eq({ex.tag, "_hold"}, dtack_l, (ex.kind == K_ACK) ? 0 : 1);
               check_eq({ex.tag, "_busy_end"}, busy, 0);
            end
            post_check = 1;
         end else if (got == K_NONE) begin
            if (!dtack_l) begin
               got = K_ACK;
               lat = edge_cnt - e_edge;
            end else if (!berr_l) begin
               got = K_BERR;
               lat = edge_cnt - e_edge;
            end
         end
      end
   end

   // One bus cycle: AS_L low for k edges after E, optional DRAM ack at E+dram_at
   task automatic run_cycle(input string tag, input logic [4:0] s, input int k,
                            input int dram_at, input int kind, input int lat,
                            input int idle);
      exp_t ex;
      ex.tag  = tag;
      ex.kind = kind;
      ex.lat  = lat;
      @(negedge clk);
      sb.push_back(ex);
      sel  = s;
      as_l = 1'b0;
      for (int i = 1; i <= k; i++) begin
         @(negedge clk);
         if (i == dram_at) dram_dtack_l = 1'b0;
         // decoder selects changing mid-cycle must be ignored
         if (i == 1) sel = ~s;
      end
      as_l = 1'b1;
      sel  = '0;
      dram_dtack_l = 1'b1;
      repeat (idle - 1) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL sim_timeout actual=running required=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      repeat (3) @(negedge clk);
      check_eq("rst_dtack", dtack_l, 1);
      check_eq("rst_berr", berr_l, 1);
      check_eq("rst_busy", busy, 0);
      rst = 1'b0;
      @(negedge clk);

      run_cycle("rom",      SEL_ROM,            5,  -1, K_ACK, ROM_W + 2, 1);
      run_cycle("rom_b2b",  SEL_ROM,            5,  -1, K_ACK, ROM_W + 2, 2);
      run_cycle("io",       SEL_IO,             7,  -1, K_ACK, IO_W + 2,  2);
      run_cycle("ram_dram", SEL_RAM | SEL_DRAM, 6,   1, K_ACK, RAM_W + 2, 2);
      run_cycle("dram",     SEL_DRAM,           9,   5, K_ACK, 6,         2);
`ifdef DTACK_BUS_TIMEOUT_EN
      run_cycle("none",     5'b00000,          20,  -1, K_BERR, TMO,      2);
`else
      run_cycle("none",     5'b00000,          20,  -1, K_NONE, 0,        2);
`endif
      run_cycle("can_abort", SEL_CAN,           3,  -1, K_NONE, 0,         1);
      run_cycle("can",       SEL_CAN,           9,  -1, K_ACK, CAN_W + 2,  2);

      // Asynchronous reset while holding DTACK_L low
      @(negedge clk);
      sel  = SEL_ROM;
      as_l = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("pre_rst_dtack", dtack_l, 0);
      #1 rst = 1'b1;
      #1;
      check_eq("async_rst_dtack", dtack_l, 1);
      check_eq("async_rst_busy", busy, 0);
      check_eq("async_rst_berr", berr_l, 1);
      #1 rst = 1'b0;
      drop_cycle = 1;
      begin
         exp_t ex;
         ex.tag  = "post_rst";
         ex.kind = K_ACK;
         ex.lat  = ROM_W + 2;
         sb.push_back(ex);
      end
      repeat (5) @(negedge clk);
      as_l = 1'b1;
      sel  = '0;

      for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      check_eq("sb_empty", sb.size(), 0);
      check_eq("no_overlap", overlap_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
